rv_exec_unit: RTL

RV_EXEC_UNIT -- requirements
Module: rv_exec_unit

---
 rtl/rv_exec_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_exec_unit.sv
// RV integer execution unit: single-cycle ALU with an optional iterative multiply/divide datapath.
// Define RV_EXEC_MEXT_EN to build the multiply/divide path and op codes 20-26.
module rv_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    // Handshake: a request transfers on in_valid && in_ready, a result on out_valid && out_ready;
    // result and illegal hold while out_valid is high and out_ready is low.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3;
    localparam logic [5:0] OP_SLTU = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8,  OP_AND   = 6'd9,  OP_ADDI  = 6'd10, OP_SLTI  = 6'd11;
    localparam logic [5:0] OP_SLTIU = 6'd12, OP_XORI = 6'd13, OP_ORI   = 6'd14, OP_ANDI  = 6'd15;
    localparam logic [5:0] OP_BYPASS = 6'd16, OP_JALR = 6'd17, OP_NOP  = 6'd18;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] sum;
    logic [SHW-1:0]  shamt;
    logic            accept;

`ifdef RV_EXEC_MEXT_EN
    localparam logic [5:0] OP_MUL = 6'd20, OP_MULH = 6'd21, OP_MULHU = 6'd22;
    localparam logic [5:0] OP_DIV = 6'd23, OP_DIVU = 6'd24, OP_REM  = 6'd25, OP_REMU = 6'd26;
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] DIV_FIX  = CW'(XLEN);

    logic [5:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic            is_mext, mul_busy, in_signed;
    logic [XLEN-1:0] madd_in, rem_sub, mhi;
    logic [XLEN:0]   madd, rem_sh;
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        shamt   = b[SHW-1:0];
        sum     = a + b;
        case (op)
            OP_ADD, OP_ADDI:   alu_res = sum;
            OP_SUB:            alu_res = a - b;
            OP_SLL:            alu_res = a << shamt;
            OP_SLT, OP_SLTI:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU, OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR, OP_XORI:   alu_res = a ^ b;
            OP_SRL:            alu_res = a >> shamt;
            OP_SRA:            alu_res = $unsigned($signed(a) >>> shamt);
            OP_OR, OP_ORI:     alu_res = a | b;
            OP_AND, OP_ANDI:   alu_res = a & b;
            OP_BYPASS:         alu_res = b;
            OP_JALR:           alu_res = {sum[XLEN-1:1], 1'b0};
            OP_NOP:            alu_res = '0;
            default:           alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept    = in_valid && in_ready;
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef RV_EXEC_MEXT_EN
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        is_mext   = (op >= OP_MUL) && (op <= OP_REMU);
        mul_busy  = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
        in_signed = (op == OP_DIV) || (op == OP_REM);
        madd_in   = lo_q[0] ? opa_q : '0;
        madd      = {1'b0, hi_q} + {1'b0, madd_in};
        rem_sh    = {hi_q, lo_q[XLEN-1]};
        rem_sub   = rem_sh[XLEN-1:0] - opb_q;
        mhi       = '0;
`endif
        if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
        if (accept) begin
            state_d   = S_DONE;
            result_d  = alu_res;
            illegal_d = alu_ill;
`ifdef RV_EXEC_MEXT_EN
            if (is_mext) begin
                state_d   = S_BUSY;
                result_d  = '0;
                illegal_d = 1'b0;
                op_d      = op;
                cnt_d     = '0;
                hi_d      = '0;
                opa_d     = a;
                // Divide runs on magnitudes; signs are re-applied in the fixup cycle.
                if (op >= OP_DIV) begin
                    lo_d   = (in_signed && a[XLEN-1]) ? -a : a;
                    opb_d  = (in_signed && b[XLEN-1]) ? -b : b;
                    qneg_d = in_signed && (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
                    rneg_d = in_signed && a[XLEN-1];
                end else begin
                    lo_d   = b;
                    opb_d  = b;
                    qneg_d = 1'b0;
                    rneg_d = 1'b0;
                end
            end
`endif
        end
`ifdef RV_EXEC_MEXT_EN
        if (state_q == S_BUSY) begin
            cnt_d = cnt_q + 1'b1;
            if (mul_busy) begin
                hi_d = madd[XLEN:1];
                lo_d = {madd[0], lo_q[XLEN-1:1]};
                if (cnt_q == MUL_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    // Signed high half = unsigned high half minus the two sign-weighted cross terms.
                    mhi = madd[XLEN:1] - (opa_q[XLEN-1] ? opb_q : '0) - (opb_q[XLEN-1] ? opa_q : '0);
                    case (op_q)
                        OP_MUL:  result_d = lo_d;
                        OP_MULH: result_d = mhi;
                        default: result_d = hi_d;
                    endcase
                end
            end else if (cnt_q == DIV_FIX) begin
                state_d = S_DONE;
                cnt_d   = '0;
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) result_d = qneg_q ? -lo_q : lo_q;
                else                                        result_d = rneg_q ? -hi_q : hi_q;
            end else if (rem_sh >= {1'b0, opb_q}) begin
                hi_d = rem_sub;
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef RV_EXEC_MEXT_EN
            op_q      <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef RV_EXEC_MEXT_EN
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule
